// File: rtl/pico_io_pkg.sv
// Shared constants and LFSR helpers for the PicoBlaze I/O hub.
package pico_io_pkg;

  // Port offsets relative to the hub base address.
  localparam logic [7:0] OFS_LED  = 8'd0;
  localparam logic [7:0] OFS_SW   = 8'd1;
  localparam logic [7:0] OFS_EVT  = 8'd2;
  localparam logic [7:0] OFS_TIME = 8'd3;
  localparam logic [7:0] OFS_TMOD = 8'd4;
  localparam logic [7:0] OFS_RND  = 8'd5;

  // Galois feedback mask and the value loaded in place of the all-zero lock-up state.
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

  // One right-shift step of the Galois LFSR.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    logic [7:0] nxt;
    if (cur[0]) begin
      nxt = (cur >> 1) ^ LFSR_TAPS;
    end else begin
      nxt = cur >> 1;
    end
    return nxt;
  endfunction

  // Seed value actually loaded; zero would freeze the register forever.
  function automatic logic [7:0] lfsr_load(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'h00) begin
      res = LFSR_ZERO_SUB;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/pico_io_hub_debounce_bit.sv
// Single switch input: two-flop synchroniser followed by a stability counter.
module debounce_bit
  import pico_io_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic db_out
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept the synchronised level only after it has differed from the stable value long enough.
  always_comb begin
    sync1_d = sw_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, stable level and counter registers; reset drops any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_out = db_q;

endmodule

// File: rtl/pico_io_hub.sv
// PicoBlaze I/O hub: LED register, debounced switches, sticky press events,
// programmable-modulus time counter and reseedable LFSR on six ports.
module pico_io_hub
  import pico_io_pkg::*;
#(
  parameter int         SW_W         = 8,
  parameter int         DEBOUNCE_CYC = 250000,
  parameter logic [7:0] BASE_ADDR    = 8'hFA,
  parameter logic [7:0] TMOD_RST     = 8'd6,
  parameter logic [7:0] LFSR_SEED    = 8'h01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      port_id,
  input  logic [7:0]      out_port,
  input  logic            write_strobe,
  input  logic            read_strobe,
  output logic [7:0]      in_port,
  input  logic [7:0]      ext_data_in,
  input  logic [SW_W-1:0] sw,
  output logic [7:0]      led,
  output logic            irq_evt
);

  logic [SW_W-1:0] sw_db_s;
  logic [7:0]      ofs_s;
  logic [7:0]      sw_db8_s, evt8_s;
  logic            wr_led_s, wr_tmod_s, wr_rnd_s, evt_clr_s;

  logic [7:0]      led_q, led_d;
  logic [7:0]      tmod_q, tmod_d;
  logic [7:0]      time_q, time_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      in_port_q, in_port_d;
  logic [SW_W-1:0] evt_q, evt_d;
  logic [SW_W-1:0] db_prev_q, db_prev_d;

  for (genvar gi = 0; gi < SW_W; gi++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .sw_in (sw[gi]),
      .db_out(sw_db_s[gi])
    );
  end

  // Address decode: offset from the base wraps in 8 bits, so hits follow BASE_ADDR+k mod 256.
  always_comb begin
    ofs_s     = port_id - BASE_ADDR;
    wr_led_s  = write_strobe && (ofs_s == OFS_LED);
    wr_tmod_s = write_strobe && (ofs_s == OFS_TMOD);
    wr_rnd_s  = write_strobe && (ofs_s == OFS_RND);
    evt_clr_s = read_strobe && (ofs_s == OFS_EVT);
  end

  // Zero-extend the switch and event vectors to the 8-bit data bus.
  always_comb begin
    sw_db8_s = 8'h00;
    evt8_s   = 8'h00;
    for (int i = 0; i < SW_W; i++) begin
      sw_db8_s[i] = sw_db_s[i];
      evt8_s[i]   = evt_q[i];
    end
  end

  // Next-state for registers, events, timer, LFSR and the registered read mux.
  always_comb begin
    if (wr_led_s) begin
      led_d = out_port;
    end else begin
      led_d = led_q;
    end

    if (wr_tmod_s) begin
      tmod_d = out_port;
    end else begin
      tmod_d = tmod_q;
    end

    // Compare against the current modulus so a new TMOD only applies from the next cycle.
    if (time_q >= tmod_q) begin
      time_d = 8'h00;
    end else begin
      time_d = time_q + 8'd1;
    end

    if (wr_rnd_s) begin
      lfsr_d = lfsr_load(out_port);
    end else begin
      lfsr_d = lfsr_step(lfsr_q);
    end

    // A rising edge in the same cycle as a clear-on-read survives the clear.
    db_prev_d = sw_db_s;
    if (evt_clr_s) begin
      evt_d = sw_db_s & ~db_prev_q;
    end else begin
      evt_d = evt_q | (sw_db_s & ~db_prev_q);
    end

    // Read data is sampled every cycle; kcpsm3 holds port_id long enough for one-cycle latency.
    case (ofs_s)
      OFS_LED:  in_port_d = led_q;
      OFS_SW:   in_port_d = sw_db8_s;
      OFS_EVT:  in_port_d = evt8_s;
      OFS_TIME: in_port_d = time_q;
      OFS_TMOD: in_port_d = tmod_q;
      OFS_RND:  in_port_d = lfsr_q;
      default:  in_port_d = ext_data_in;
    endcase
  end

  // Hub state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= 8'h00;
      tmod_q    <= TMOD_RST;
      time_q    <= 8'h00;
      lfsr_q    <= LFSR_SEED;
      in_port_q <= 8'h00;
      evt_q     <= '0;
      db_prev_q <= '0;
    end else begin
      led_q     <= led_d;
      tmod_q    <= tmod_d;
      time_q    <= time_d;
      lfsr_q    <= lfsr_d;
      in_port_q <= in_port_d;
      evt_q     <= evt_d;
      db_prev_q <= db_prev_d;
    end
  end

  assign led     = led_q;
  assign in_port = in_port_q;
  assign irq_evt = |evt_q;

endmodule

// File: tb/tb_pico_io_hub.sv
// Randomised and directed bench for pico_io_hub against a cycle-level reference model.
module tb_pico_io_hub;

  localparam logic [7:0] BASE = 8'hFA;
  localparam int         DB   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] port_id = 8'hFF;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] in_port;
  logic [7:0] ext_data_in = 8'h00;
  logic [7:0] sw = 8'h00;
  logic [7:0] led;
  logic       irq_evt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_led, m_tmod, m_time, m_lfsr, m_evt, m_in, m_s1, m_s2, m_db, m_dbp;
  int         m_run [8];

  pico_io_hub #(
    .SW_W(8), .DEBOUNCE_CYC(DB), .BASE_ADDR(BASE), .TMOD_RST(8'd6), .LFSR_SEED(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
    .ext_data_in(ext_data_in), .sw(sw), .led(led), .irq_evt(irq_evt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_led = 8'h00; m_tmod = 8'd6; m_time = 8'h00; m_lfsr = 8'h01; m_evt = 8'h00;
    m_in = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00; m_db = 8'h00; m_dbp = 8'h00;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [7:0] ofs, rd, n_db, n_evt, n_lfsr;
    int         n_run [8];
    ofs = port_id - BASE;
    case (ofs)
      8'd0:    rd = m_led;
      8'd1:    rd = m_db;
      8'd2:    rd = m_evt;
      8'd3:    rd = m_time;
      8'd4:    rd = m_tmod;
      8'd5:    rd = m_lfsr;
      default: rd = ext_data_in;
    endcase
    n_evt = (read_strobe && ofs == 8'd2) ? 8'h00 : m_evt;
    n_evt = n_evt | (m_db & ~m_dbp);
    n_db = m_db;
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] != m_db[i]) begin
        n_run[i] = m_run[i] + 1;
        if (n_run[i] == DB) begin
          n_db[i]  = m_s2[i];
          n_run[i] = 0;
        end
      end else begin
        n_run[i] = 0;
      end
    end
    if (write_strobe && ofs == 8'd5)
      n_lfsr = (out_port == 8'h00) ? 8'h01 : out_port;
    else
      n_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    m_time = (m_time >= m_tmod) ? 8'h00 : m_time + 8'd1;
    if (write_strobe && ofs == 8'd4) m_tmod = out_port;
    if (write_strobe && ofs == 8'd0) m_led = out_port;
    m_dbp = m_db; m_db = n_db; m_s2 = m_s1; m_s1 = sw;
    m_evt = n_evt; m_lfsr = n_lfsr; m_in = rd; m_run = n_run;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check8("in_port", in_port, m_in);
    check8("led", led, m_led);
    check8("irq_evt", {7'd0, irq_evt}, {7'd0, |m_evt});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check8("rst_in_port", in_port, 8'h00);
    check8("rst_led", led, 8'h00);
    check8("rst_irq", {7'd0, irq_evt}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1;
    cycle();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic stb);
    port_id = a; read_strobe = stb;
    cycle();
    read_strobe = 1'b0;
  endtask

  initial begin
    logic       found;
    logic       zero_seen;
    logic [7:0] first;
    int         n;

    // Reset and first reads: LFSR sequence from the seed, TIME in range, TMOD reset value.
    do_reset();
    rd(8'hFF, 1'b0); check8("rnd_seq0", in_port, 8'h01);
    rd(8'hFF, 1'b0); check8("rnd_seq1", in_port, 8'hB8);
    rd(8'hFF, 1'b0); check8("rnd_seq2", in_port, 8'h5C);
    rd(8'hFD, 1'b0); check8("time_range", {7'd0, in_port <= 8'd6}, 8'h01);
    rd(8'hFE, 1'b0); check8("tmod_rst", in_port, 8'h06);
    rd(8'hFA, 1'b0); check8("led_rd0", in_port, 8'h00);

    // LED write and external passthrough.
    wr(8'hFA, 8'hA5); check8("led_wr", led, 8'hA5);
    rd(8'hFA, 1'b0);  check8("led_rd", in_port, 8'hA5);
    ext_data_in = 8'h3C;
    rd(8'h10, 1'b0);  check8("ext_pass", in_port, 8'h3C);

    // Short glitch on sw[0] must be rejected.
    sw = 8'h01;
    for (int k = 0; k < 3; k++) rd(8'hFB, 1'b0);
    sw = 8'h00;
    for (int k = 0; k < 8; k++) rd(8'hFB, 1'b0);
    check8("glitch_sw", in_port, 8'h00);
    rd(8'hFC, 1'b0); check8("glitch_evt", in_port, 8'h00);

    // Held level: stable after 2 sync + DB cycles, visible on the read one cycle later.
    sw = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      rd(8'hFB, 1'b0);
      if (k == 6) check8("db_early", in_port, 8'h00);
      if (k == 7) check8("db_accept", in_port, 8'h01);
    end
    rd(8'hFC, 1'b0); check8("evt_set", in_port, 8'h01);
    check8("irq_set", {7'd0, irq_evt}, 8'h01);

    // Clear-on-read racing a new sw[1] rise.
    sw = 8'h03;
    for (int k = 0; k < 6; k++) rd(8'hFB, 1'b0);
    rd(8'hFC, 1'b1); check8("race_rd", in_port, 8'h01);
    check8("race_irq", {7'd0, irq_evt}, 8'h01);
    rd(8'hFC, 1'b1); check8("race_rd2", in_port, 8'h02);
    check8("race_irq_clr", {7'd0, irq_evt}, 8'h00);
    rd(8'hFC, 1'b0); check8("evt_clear", in_port, 8'h00);

    // TIME with modulus 3, then modulus 0 while TIME is 3.
    wr(8'hFE, 8'd3);
    port_id = 8'hFD;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (in_port == 8'h00) found = 1'b1;
    end
    check8("time_wrap_seen", {7'd0, found}, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check8("time_seq", in_port, 8'(k % 4));
    end
    n = 0;
    while (m_time != 8'd3 && n < 10) begin
      cycle();
      n++;
    end
    check8("time_at3", m_time, 8'd3);
    wr(8'hFE, 8'd0);
    port_id = 8'hFD;
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check8("time_hold0", in_port, 8'h00);
    end

    // LFSR reseed with zero substitution and a plain seed.
    wr(8'hFF, 8'h00);
    rd(8'hFF, 1'b0); check8("rnd_zero_sub", in_port, 8'h01);
    rd(8'hFF, 1'b0); check8("rnd_after_sub", in_port, 8'hB8);
    wr(8'hFF, 8'h80);
    rd(8'hFF, 1'b0); check8("rnd_80", in_port, 8'h80);
    rd(8'hFF, 1'b0); check8("rnd_40", in_port, 8'h40);
    rd(8'hFF, 1'b0); check8("rnd_20", in_port, 8'h20);
    first = in_port;
    zero_seen = 1'b0;
    for (int k = 0; k < 255; k++) begin
      rd(8'hFF, 1'b0);
      if (in_port == 8'h00) zero_seen = 1'b1;
    end
    check8("rnd_nonzero", {7'd0, zero_seen}, 8'h00);
    check8("rnd_period", in_port, first);

    // Random traffic, including a reset in the middle of a debounce.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4, 5: port_id = BASE + 8'($urandom_range(0, 5));
        6:                port_id = 8'($urandom);
        default:          port_id = 8'hFC;
      endcase
      out_port     = 8'($urandom);
      ext_data_in  = 8'($urandom);
      write_strobe = ($urandom_range(0, 3) == 0);
      read_strobe  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      if (i == 300) begin
        sw = ~sw;
        cycle();
        cycle();
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        do_reset();
      end else begin
        cycle();
      end
    end
    write_strobe = 1'b0;
    read_strobe  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
